// File: rtl/apb_slave_mem.sv
// APB completer fronting a 256 x 8 memory with programmable wait states,
// a read-only upper region and protocol-violation error reporting.
module apb_slave_mem #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic        SLV_ID      = 1'b0,
  parameter logic [7:0]  RO_BASE     = 8'hF0
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [8:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic       PREADY,
  output logic [7:0] PRDATA,
  output logic       PSLVERR
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e     r_state, w_state_d;
  logic [2:0] r_cnt, w_cnt_d;
  logic [8:0] r_addr, w_addr_d;
  logic       r_write, w_write_d;
  logic [7:0] r_wdata, w_wdata_d;
  logic       r_err, w_err_d;
  logic       r_pready, w_pready_d;
  logic [7:0] r_prdata, w_prdata_d;
  logic       r_pslverr, w_pslverr_d;
  logic       w_mem_we;
  logic       w_setup_err;
  logic       w_mismatch;
  logic       w_err_acc;
  logic [7:0] r_mem [256];

  assign w_setup_err = (PADDR[8] != SLV_ID) || (PWRITE && (PADDR[7:0] >= RO_BASE));
  // Write data only has to stay stable for writes.
  assign w_mismatch  = (PADDR != r_addr) || (PWRITE != r_write) ||
                       (r_write && (PWDATA != r_wdata));
  assign w_err_acc   = r_err | w_mismatch;

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_addr_d    = r_addr;
    w_write_d   = r_write;
    w_wdata_d   = r_wdata;
    w_err_d     = r_err;
    w_pready_d  = 1'b0;
    w_prdata_d  = 8'h00;
    w_pslverr_d = 1'b0;
    w_mem_we    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (PSEL && !PENABLE) begin
          w_state_d = StWait;
          w_cnt_d   = 3'(WAIT_CYCLES);
          w_addr_d  = PADDR;
          w_write_d = PWRITE;
          w_wdata_d = PWDATA;
          w_err_d   = w_setup_err;
        end else if (PSEL && PENABLE) begin
          // Access phase without a setup phase: complete immediately with an error.
          w_state_d   = StResp;
          w_pready_d  = 1'b1;
          w_pslverr_d = 1'b1;
        end
      end
      StWait: begin
        if (!PSEL) begin
          w_state_d = StIdle;
        end else if (!PENABLE) begin
          w_state_d = StWait;
          w_cnt_d   = 3'(WAIT_CYCLES);
          w_addr_d  = PADDR;
          w_write_d = PWRITE;
          w_wdata_d = PWDATA;
          w_err_d   = w_setup_err;
        end else if (r_cnt != 3'd0) begin
          w_cnt_d = r_cnt - 3'd1;
          w_err_d = w_err_acc;
        end else begin
          w_state_d   = StResp;
          w_err_d     = w_err_acc;
          w_pready_d  = 1'b1;
          w_pslverr_d = w_err_acc;
          w_mem_we    = r_write && !w_err_acc;
          w_prdata_d  = (!r_write && !w_err_acc) ? r_mem[r_addr[7:0]] : 8'h00;
        end
      end
      StResp: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state   <= StIdle;
      r_cnt     <= 3'd0;
      r_addr    <= 9'h000;
      r_write   <= 1'b0;
      r_wdata   <= 8'h00;
      r_err     <= 1'b0;
      r_pready  <= 1'b0;
      r_prdata  <= 8'h00;
      r_pslverr <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_addr    <= w_addr_d;
      r_write   <= w_write_d;
      r_wdata   <= w_wdata_d;
      r_err     <= w_err_d;
      r_pready  <= w_pready_d;
      r_prdata  <= w_prdata_d;
      r_pslverr <= w_pslverr_d;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < 256; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else if (w_mem_we) begin
      r_mem[r_addr[7:0]] <= r_wdata;
    end
  end

  assign PREADY  = r_pready;
  assign PRDATA  = r_prdata;
  assign PSLVERR = r_pslverr;

endmodule

// File: doc/apb_slave_mem.md
APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, meaning access-phase wait states inserted before PREADY, legal range 0..7.
REQ-002 The block SHALL have parameter SLV_ID, default 1'b0, meaning the PADDR[8] value this completer owns.
REQ-003 The block SHALL have parameter RO_BASE, default 8'hF0, meaning the lowest read-only offset; offsets RO_BASE..8'hFF reject writes.
REQ-004 The block SHALL have port PCLK, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port PRESET, input, 1 bit, reset; synchronous and active-high.
REQ-006 The block SHALL have port PSEL, input, 1 bit, completer select.
REQ-007 The block SHALL have port PENABLE, input, 1 bit, access-phase indicator.
REQ-008 The block SHALL have port PWRITE, input, 1 bit, 1 = write, 0 = read.
REQ-009 The block SHALL have port PADDR, input, 9 bits; [8] completer select, [7:0] memory offset.
REQ-010 The block SHALL have port PWDATA, input, 8 bits, write data.
REQ-011 The block SHALL have port PREADY, output, 1 bit, registered transfer-complete.
REQ-012 The block SHALL have port PRDATA, output, 8 bits, registered read data.
REQ-013 The block SHALL have port PSLVERR, output, 1 bit, registered error response.

Function
REQ-014 Storage SHALL be 256 x 8 bits, indexed by PADDR[7:0].
REQ-015 The FSM SHALL have states IDLE, WAIT, RESP; RESP lasts exactly one cycle.
REQ-016 IDLE with PSEL=1, PENABLE=0 (setup cycle) SHALL capture PADDR, PWRITE, PWDATA and go to WAIT with counter = WAIT_CYCLES.
REQ-017 WAIT with PSEL=1, PENABLE=1 and counter != 0 SHALL decrement the counter and keep PREADY=0.
REQ-018 WAIT with PSEL=1, PENABLE=1 and counter = 0 SHALL go to RESP, setting PREADY=1 for the next cycle; PREADY=1 therefore occurs in access cycle WAIT_CYCLES+2 after setup (WAIT_CYCLES=0: second access cycle).
REQ-019 RESP SHALL drive PREADY=1 for one cycle and return to IDLE; the next cycle may be a new setup (back-to-back supported).
REQ-020 A transfer SHALL be errored if captured PADDR[8] != SLV_ID, if it is a write to an offset >= RO_BASE, or if PADDR/PWRITE/PWDATA (PWDATA for writes only) differ from the captured values in any access cycle.
REQ-021 In RESP, PSLVERR SHALL be 1 for errored transfers and 0 otherwise; outside RESP PSLVERR SHALL be 0.
REQ-022 A non-errored write SHALL update memory at the clock edge entering RESP; an errored write SHALL leave memory unchanged.
REQ-023 In RESP, PRDATA SHALL hold mem[offset] for non-errored reads and 8'h00 for writes and errored transfers; outside RESP PRDATA SHALL be 8'h00.
REQ-024 IDLE with PSEL=1, PENABLE=1 (access without setup) SHALL go to RESP with PSLVERR=1, PRDATA=0, no memory effect.
REQ-025 PSEL=0 in WAIT SHALL abort: return to IDLE, no memory effect, PREADY stays 0.
REQ-026 WAIT with PSEL=1, PENABLE=0 SHALL be treated as a new setup cycle: recapture and reload counter.
REQ-027 A read of an offset written in the immediately preceding transfer SHALL return the new data.

Reset
REQ-028 PRESET=1 at a rising PCLK edge SHALL force IDLE, PREADY=0, PRDATA=8'h00, PSLVERR=0, counter=0, and clear all memory to 8'h00.
REQ-029 PRESET asserted mid-transfer SHALL abandon it with no memory write; PRESET dominates all other inputs.

Verification
REQ-030 WAIT_CYCLES=2, SLV_ID=0: write 0x05<-8'hA5 then read 0x05 -> PREADY high in 4th access cycle each, PSLVERR=0, PRDATA=8'hA5.
REQ-031 Write 0x0F3<-8'h11 (RO region) then read 0x0F3 -> write PSLVERR=1; read returns 8'h00, PSLVERR=0.
REQ-032 Read address 9'h105 with SLV_ID=0 -> PSLVERR=1, PRDATA=8'h00 in RESP.
REQ-033 WAIT_CYCLES=0: back-to-back writes 0x01<-8'h01, 0x02<-8'h02, then reads -> PREADY in 2nd access cycle each, data 8'h01, 8'h02.
REQ-034 PADDR changed during wait cycles of a write to 0x10 -> PSLVERR=1, mem[0x10] remains 8'h00.
REQ-035 PRESET=1 during WAIT of a write to 0x20 -> outputs 0 next cycle, later read of 0x20 returns 8'h00.
